// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_pkg
//  Description : Shared select codes, register constants and pipeline slot
//                record for the EX-stage forwarding select controller.
//  Revision    : 1.0  initial release
// ============================================================================
package fwd_pkg;

    localparam int ADDR_W = 3;

    localparam logic [1:0] SEL_RF      = 2'b00;
    localparam logic [1:0] SEL_MEM     = 2'b01;
    localparam logic [1:0] SEL_WB      = 2'b10;
    localparam logic [1:0] SEL_ILLEGAL = 2'b11;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef logic [1:0] sel_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic              we;
        logic              is_load;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/fwd_sel_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_sel_ctrl_if
//  Description : ID-side request bundle and EX-side select/stall responses.
//  Revision    : 1.0  initial release
// ============================================================================
interface fwd_sel_ctrl_if #(
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_we;
    logic                  id_is_load;
    logic                  flush;
    logic [1:0]            ex_sel_a;
    logic [1:0]            ex_sel_b;
    logic                  stall;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_we, id_is_load, flush,
        input  ex_sel_a, ex_sel_b, stall, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_we, id_is_load, flush,
        output ex_sel_a, ex_sel_b, stall, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/fwd_match.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_match
//  Description : Per-operand producer match; picks the youngest forwardable
//                in-flight result for one source specifier.
//  Revision    : 1.0  initial release
// ============================================================================
module fwd_match
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = ADDR_W
) (
    input  wire logic [REG_ADDR_W-1:0] i_rs,
    input  wire slot_t                 i_ex,
    input  wire slot_t                 i_mem,
    output sel_t                       o_sel
);

    logic w_rs_nz;
    logic w_ex_hit;
    logic w_mem_hit;
    logic w_unused_mem_load;

    assign w_rs_nz = (i_rs != REG_ZERO);

    // A load still in EX cannot forward from MEM next cycle; the stall covers it.
    assign w_ex_hit  = i_ex.valid & i_ex.we & ~i_ex.is_load & (i_ex.rd == i_rs) & w_rs_nz;
    assign w_mem_hit = i_mem.valid & i_mem.we & (i_mem.rd == i_rs) & w_rs_nz;

    assign w_unused_mem_load = i_mem.is_load;

    always_comb begin
        o_sel = SEL_RF;
        if (w_ex_hit) begin
            o_sel = SEL_MEM;
        end else if (w_mem_hit) begin
            o_sel = SEL_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fwd_sel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_sel_ctrl
//  Description : EX-stage forwarding select generator with load-use stall
//                detection and a saturating stall-cycle counter.
//  Revision    : 1.0  initial release
// ============================================================================
module fwd_sel_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = ADDR_W,
    parameter int CNT_W      = 16
) (
    input wire logic      clk,
    input wire logic      rst,
    fwd_sel_ctrl_if.slave bus
);

    slot_t            r_ex;
    slot_t            r_mem;
    slot_t            r_wb;
    sel_t             r_sel_a;
    sel_t             r_sel_b;
    logic [CNT_W-1:0] r_stall_count;

    slot_t            w_id_slot;
    sel_t             w_sel_a;
    sel_t             w_sel_b;
    logic             w_src_hit;
    logic             w_stall;
    logic             w_enter;
    logic             w_cnt_max;
    logic             w_unused_wb;

    always_comb begin
        w_id_slot         = SLOT_BUBBLE;
        w_id_slot.valid   = 1'b1;
        w_id_slot.rd      = bus.id_rd;
        w_id_slot.we      = bus.id_we;
        w_id_slot.is_load = bus.id_is_load;
    end

    assign w_src_hit = (r_ex.rd == bus.id_rs1) | (r_ex.rd == bus.id_rs2);
    assign w_stall   = bus.id_valid & r_ex.valid & r_ex.we & r_ex.is_load &
                       (r_ex.rd != REG_ZERO) & w_src_hit & ~bus.flush;

    assign w_enter   = bus.id_valid & ~w_stall & ~bus.flush;
    assign w_cnt_max = &r_stall_count;

    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_a (
        .i_rs  (bus.id_rs1),
        .i_ex  (r_ex),
        .i_mem (r_mem),
        .o_sel (w_sel_a)
    );

    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_b (
        .i_rs  (bus.id_rs2),
        .i_ex  (r_ex),
        .i_mem (r_mem),
        .o_sel (w_sel_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex          <= SLOT_BUBBLE;
            r_mem         <= SLOT_BUBBLE;
            r_wb          <= SLOT_BUBBLE;
            r_sel_a       <= SEL_RF;
            r_sel_b       <= SEL_RF;
            r_stall_count <= '0;
        end else begin
            r_wb    <= r_mem;
            // A flushed EX instruction is squashed rather than advanced.
            r_mem   <= bus.flush ? SLOT_BUBBLE : r_ex;
            r_ex    <= w_enter ? w_id_slot : SLOT_BUBBLE;
            r_sel_a <= w_enter ? w_sel_a : SEL_RF;
            r_sel_b <= w_enter ? w_sel_b : SEL_RF;
            if (w_stall && !w_cnt_max) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    // WB only retires here; it is kept for pipeline visibility.
    assign w_unused_wb = ^r_wb;

    assign bus.ex_sel_a    = r_sel_a;
    assign bus.ex_sel_b    = r_sel_b;
    assign bus.stall       = w_stall;
    assign bus.stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: doc/fwd_sel_ctrl.md
Name: fwd_sel_ctrl

Overview:
- Generates the 2-bit select codes for the three-input operand forwarding muxes in the EX stage.
- Mux input map: 00 = register-file data, 01 = MEM-stage result, 10 = WB-stage result, 11 = undriven/illegal.
- Tracks destination registers in flight through its own EX/MEM/WB shadow slots.
- Detects load-use hazards, inserts a one-cycle stall, and keeps a saturating count of stall cycles.
- Sits beside the ID/EX pipeline register and drives the select lines the forwarding muxes consume.

Parameters:
- REG_ADDR_W, 3, width of register specifiers (8 architectural registers; R0 hardwired zero).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  REG_ADDR_W  source A specifier of the ID instruction.
- id_rs2  in  REG_ADDR_W  source B specifier of the ID instruction.
- id_rd  in  REG_ADDR_W  destination of the ID instruction.
- id_we  in  1  ID instruction writes id_rd.
- id_is_load  in  1  ID instruction is a load; its data is first available at WB.
- flush  in  1  squash the ID and EX instructions (branch redirect).
- ex_sel_a  out  2  forwarding mux select for operand A; valid while the instruction is in EX.
- ex_sel_b  out  2  forwarding mux select for operand B.
- stall  out  1  hold PC and IF/ID; combinational.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset: clk edge with rst=1 clears all slots.
  - EX/MEM/WB slot valid bits, ex_sel_a, ex_sel_b and stall_count go to 0; stall reads 0 in the following cycle.
  - rst overrides flush and every other input.
  - Reset mid-stall discards the pending hazard.
- Slots: each slot holds {valid, rd, we, is_load}.
  - Each edge without stall or flush shifts ID -> EX -> MEM -> WB; the WB contents retire.
- Stall (combinational):
  - stall = id_valid & EX.valid & EX.we & EX.is_load & (EX.rd != 0) & (EX.rd == id_rs1 | EX.rd == id_rs2) & ~flush.
  - On a stall edge, EX -> MEM and MEM -> WB still shift, and a bubble (valid=0) enters EX.
  - ex_sel_a/b go to 00 for the bubble.
  - ID is held externally; the stall therefore lasts exactly one cycle.
- Select computation: registered at the edge the ID instruction enters EX, per operand (rs = id_rs1 or id_rs2).
  - 01 if EX.valid & EX.we & ~EX.is_load & EX.rd == rs & rs != 0. That producer is in MEM when the consumer is in EX.
  - Else 10 if MEM.valid & MEM.we & MEM.rd == rs & rs != 0. Covers ALU results and loads; the load case occurs only after the stall.
  - Else 00.
  - Priority: the youngest producer (01) beats the older one (10).
  - 11 is never driven. A bench check asserts this every cycle.
- id_valid=0: a bubble enters EX with sel 00; no stall.
- Flush: at the edge, the EX slot receives a bubble and the previous EX contents are discarded, not moved to MEM.
  - MEM -> WB still shifts.
  - sel goes to 00; stall is forced to 0 in that cycle.
- stall_count:
  - Increments on every edge where stall=1 and rst=0.
  - Saturates at all-ones and does not wrap.
- Latency: sel is valid one cycle after the ID-side inputs are sampled.

Decomposition:
- Shared package (fwd_pkg):
  - SEL_RF=2'b00, SEL_MEM=2'b01, SEL_WB=2'b10, SEL_ILLEGAL=2'b11;
  - REG_ZERO;
  - slot record typedef {valid, rd, we, is_load}.
- Sub-module fwd_match: combinational per-operand compare producing a select code.
  - Instantiated twice, for operands A and B.
- Top-level module holds the slot registers, the stall logic and the counter.

Test Plan:
- Reset: assert rst 2 cycles with arbitrary inputs -> ex_sel_a=ex_sel_b=00, stall=0, stall_count=0.
- EX forward: ADD rd=3, then next-cycle consumer rs1=3 rs2=5 -> that cycle ex_sel_a=01, ex_sel_b=00, stall never 1.
- WB forward and priority:
  - rd=4 write, one independent instruction, then rs2=4 -> ex_sel_b=10.
  - Two back-to-back writes to rd=4, then rs1=4 -> ex_sel_a=01.
- Load-use: LOAD rd=2, then rs1=2 -> stall=1 for exactly 1 cycle; bubble sel 00; consumer then has ex_sel_a=10; stall_count=1.
- R0 and flush:
  - Write rd=0, then rs1=0 -> sel 00.
  - LOAD rd=6 with consumer rs2=6 and flush=1 in the same cycle -> stall=0, next cycle sel 00, stall_count unchanged.
- Saturation: CNT_W=2, five load-use stalls -> stall_count stops at 3; ex_sel never 11 throughout.
